// File: rtl/cache_fill_fsm.sv
// Line-fill engine for the 2-way, 64-set cache: latches the missing line and victim way,
// streams 8 word requests to memory and writes each returned word into the data array.
// Installs the tag and marks the filled way MRU in a final one-cycle DONE state.
module cache_fill_fsm #(
  parameter int ADDR_W   = 16,
  parameter int NUM_SETS = 64,
  parameter int WORDS    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        miss_detected,
  input  logic [ADDR_W-1:0]           miss_address,
  input  logic                        block0_isLRU,
  input  logic [15:0]                 mem_data,
  input  logic                        mem_data_valid,
  output logic                        fsm_busy,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [NUM_SETS-1:0]         set_enable,
  output logic                        way_sel,
  output logic [$clog2(WORDS)-1:0]    data_word_sel,
  output logic                        write_data_array,
  output logic [15:0]                 data_out,
  output logic                        write_tag_array,
  output logic [ADDR_W-$clog2(NUM_SETS)-$clog2(WORDS)-2:0] tag_out,
  output logic                        lru_wen,
  output logic                        lru_block,
  output logic                        fill_done
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WRD_W  = $clog2(WORDS);
  localparam int OFF_W  = WRD_W + 1;            // 16-bit words: byte offset = word + 1 bit
  localparam int LINE_W = ADDR_W - OFF_W;       // {tag, index}
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                way_q, way_d;
  logic [WRD_W-1:0]    req_cnt_q, req_cnt_d;
  logic                req_all_q, req_all_d;   // all WORDS requests issued; stops the 3-bit counter wrapping into a 9th
  logic [WRD_W-1:0]    rcv_cnt_q, rcv_cnt_d;

  // The byte offset of the miss never matters: the whole line is fetched from word 0.
  logic unused_offset;
  assign unused_offset = ^miss_address[OFF_W-1:0];

  // State and datapath registers, synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      way_q     <= 1'b0;
      req_cnt_q <= '0;
      req_all_q <= 1'b0;
      rcv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      way_q     <= way_d;
      req_cnt_q <= req_cnt_d;
      req_all_q <= req_all_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

  // Next state: accept a miss only from IDLE; leave FILL on the last returned word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (miss_detected) state_d = FILL;
      FILL: if (mem_data_valid && (rcv_cnt_q == LAST_WORD)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latches and word counters: address/victim captured once at acceptance, counters step per request/return.
  always_comb begin
    line_d    = line_q;
    way_d     = way_q;
    req_cnt_d = req_cnt_q;
    req_all_d = req_all_q;
    rcv_cnt_d = rcv_cnt_q;
    if (state_q == IDLE) begin
      if (miss_detected) begin
        line_d    = miss_address[ADDR_W-1:OFF_W];
        way_d     = ~block0_isLRU;
        req_cnt_d = '0;
        req_all_d = 1'b0;
        rcv_cnt_d = '0;
      end
    end else if (state_q == FILL) begin
      if (!req_all_q) begin
        req_cnt_d = req_cnt_q + 1'b1;
        if (req_cnt_q == LAST_WORD) req_all_d = 1'b1;
      end
      if (mem_data_valid) rcv_cnt_d = rcv_cnt_q + 1'b1;
    end
  end

  // Outputs decoded from the current state; data array writes follow mem_data_valid combinationally.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    mem_addr         = '0;
    set_enable       = '0;
    data_word_sel    = '0;
    write_data_array = 1'b0;
    data_out         = '0;
    write_tag_array  = 1'b0;
    lru_wen          = 1'b0;
    lru_block        = 1'b0;
    fill_done        = 1'b0;
    way_sel          = way_q;
    tag_out          = line_q[LINE_W-1:IDX_W];
    unique case (state_q)
      FILL: begin
        fsm_busy      = 1'b1;
        set_enable    = NUM_SETS'(1) << line_q[IDX_W-1:0];
        data_word_sel = rcv_cnt_q;
        if (!req_all_q) begin
          mem_rd_en = 1'b1;
          mem_addr  = {line_q, req_cnt_q, 1'b0};
        end
        if (mem_data_valid) begin
          write_data_array = 1'b1;
          data_out         = mem_data;
        end
      end
      DONE: begin
        fsm_busy        = 1'b1;
        set_enable      = NUM_SETS'(1) << line_q[IDX_W-1:0];
        write_tag_array = 1'b1;
        lru_wen         = 1'b1;
        lru_block       = way_q;
        fill_done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed scenarios plus random fills against a schedule-based model.
// Expected outputs are derived from the bench's own valid-return schedule for each fill.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_cache_fill_fsm;
  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        block0_isLRU;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic        fsm_busy;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [63:0] set_enable;
  logic        way_sel;
  logic [2:0]  data_word_sel;
  logic        write_data_array;
  logic [15:0] data_out;
  logic        write_tag_array;
  logic [5:0]  tag_out;
  logic        lru_wen;
  logic        lru_block;
  logic        fill_done;

  int total = 0;
  int bad   = 0;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .block0_isLRU(block0_isLRU), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .fsm_busy(fsm_busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .set_enable(set_enable),
    .way_sel(way_sel), .data_word_sel(data_word_sel), .write_data_array(write_data_array),
    .data_out(data_out), .write_tag_array(write_tag_array), .tag_out(tag_out),
    .lru_wen(lru_wen), .lru_block(lru_block), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Everything that must be quiet when no fill is active.
  task automatic chk_quiet(input string pfx);
    chk({pfx, "_busy"},  64'(fsm_busy), 64'd0);
    chk({pfx, "_rd"},    64'(mem_rd_en), 64'd0);
    chk({pfx, "_set"},   set_enable, 64'd0);
    chk({pfx, "_wdat"},  64'(write_data_array), 64'd0);
    chk({pfx, "_wtag"},  64'(write_tag_array), 64'd0);
    chk({pfx, "_lru"},   64'(lru_wen), 64'd0);
    chk({pfx, "_done"},  64'(fill_done), 64'd0);
  endtask

  // Idle cycles with random valid pulses: nothing may be written, no fill may start.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      miss_detected  = 1'b0;
      mem_data_valid = 1'($urandom);
      mem_data       = 16'($urandom);
      #1;
      chk_quiet("idle");
    end
    mem_data_valid = 1'b0;
  endtask

  // One fill. mode 0: returns at request+4; mode 1: returns on alternate cycles; mode 2: random gaps.
  // hold_miss keeps miss_detected high after acceptance; abort_after>0 asserts rst after that many words;
  // spurious drives an extra valid in the DONE cycle.
  task automatic run_fill(input logic [15:0] addr, input logic lru, input int mode,
                          input bit hold_miss, input int abort_after, input bit spurious);
    int t[8];
    int prev = 0;
    int lo;
    int k = 0;
    int last;
    logic [11:0] line = addr[15:4];
    logic        way  = ~lru;
    bit          real_w;
    for (int w = 0; w < 8; w++) begin
      lo = w + 1 + 4;
      if (mode == 0)      t[w] = lo;
      else if (mode == 1) t[w] = 5 + 2 * w;
      else begin
        t[w] = (lo > prev + 1) ? lo : prev + 1;
        t[w] = t[w] + int'($urandom_range(0, 2));
      end
      prev = t[w];
    end
    last = t[7];
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      mem_data = 16'($urandom);
      if (c == 0) begin
        miss_detected = 1'b1;
        miss_address  = addr;
        block0_isLRU  = lru;
      end else begin
        miss_detected = hold_miss;
        miss_address  = 16'($urandom);
        block0_isLRU  = 1'($urandom);
      end
      if (abort_after > 0 && k == abort_after) begin
        rst = 1'b1;
        mem_data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        miss_detected = 1'b0;
        mem_data_valid = 1'b1;
        #1;
        chk_quiet("abort");
        chk("abort_way",  64'(way_sel), 64'd0);
        chk("abort_tag",  64'(tag_out), 64'd0);
        chk("abort_addr", 64'(mem_addr), 64'd0);
        chk("abort_wsel", 64'(data_word_sel), 64'd0);
        mem_data_valid = 1'b0;
        return;
      end
      real_w = (k < 8) && (c == t[k]);
      mem_data_valid = real_w || (spurious && c == last + 1);
      #1;
      if (c == 0) begin
        chk("accept_busy", 64'(fsm_busy), 64'd0);
        chk("accept_wdat", 64'(write_data_array), 64'd0);
      end else begin
        chk("busy", 64'(fsm_busy), 64'd1);
        chk("set_enable", set_enable, 64'd1 << line[5:0]);
        chk("way_sel", 64'(way_sel), 64'(way));
        chk("rd_en", 64'(mem_rd_en), 64'(c <= 8));
        if (c <= 8) chk("mem_addr", 64'(mem_addr), 64'({line, 3'(c - 1), 1'b0}));
        chk("wdat", 64'(write_data_array), 64'(real_w));
        if (real_w) begin
          chk("word_sel", 64'(data_word_sel), 64'(k));
          chk("data_out", 64'(data_out), 64'(mem_data));
          k++;
        end
        chk("wtag",   64'(write_tag_array), 64'(c == last + 1));
        chk("lru_wen", 64'(lru_wen), 64'(c == last + 1));
        chk("done",   64'(fill_done), 64'(c == last + 1));
        if (c == last + 1) begin
          chk("lru_block", 64'(lru_block), 64'(way));
          chk("tag_out", 64'(tag_out), 64'(line[11:6]));
        end
      end
    end
    mem_data_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    block0_isLRU = 1'b0;
    mem_data = '0;
    mem_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_way",  64'(way_sel), 64'd0);
    chk("reset_tag",  64'(tag_out), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_wsel", 64'(data_word_sel), 64'd0);
    chk("reset_dout", 64'(data_out), 64'd0);
    rst = 1'b0;

    // 1: canonical fill, index 35, tag 6, way 0
    run_fill(16'h1A36, 1'b1, 0, 1'b0, 0, 1'b0);
    idle_cycles(2);
    // 2: way 1 victim, block0_isLRU randomised mid-fill
    run_fill(16'(16'h8000 | $urandom), 1'b0, 0, 1'b0, 0, 1'b0);
    idle_cycles(1);
    // 3: returns on alternate cycles
    run_fill(16'($urandom), 1'($urandom), 1, 1'b0, 0, 1'b0);
    idle_cycles(1);
    // 4: miss held high, back-to-back fills with one idle cycle between
    run_fill(16'($urandom), 1'($urandom), 0, 1'b1, 0, 1'b0);
    run_fill(16'($urandom), 1'($urandom), 2, 1'b1, 0, 1'b0);
    run_fill(16'($urandom), 1'($urandom), 0, 1'b0, 0, 1'b0);
    idle_cycles(2);
    // 5: reset after 3 words, then a clean fill
    run_fill(16'($urandom), 1'($urandom), 0, 1'b0, 3, 1'b0);
    idle_cycles(2);
    run_fill(16'($urandom), 1'($urandom), 2, 1'b0, 0, 1'b0);
    idle_cycles(1);
    // 6: spurious valid in DONE and valid pulses while idle
    run_fill(16'($urandom), 1'($urandom), 0, 1'b0, 0, 1'b1);
    idle_cycles(6);
    run_fill(16'($urandom), 1'($urandom), 0, 1'b0, 0, 1'b0);
    // random fills
    for (int i = 0; i < 8; i++) begin
      run_fill(16'($urandom), 1'($urandom), 2, 1'($urandom), 0, 1'($urandom));
      idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
